child_rr_scheduler: RTL and testbench
=====================================

Name: child_rr_scheduler

Overview:
- Round-robin scheduler that shares one resource slot among the five child instances of a root module (inst_0..inst_4).
- Each child raises a request. The scheduler grants exactly one child at a time, holds the grant until the child signals done or a hold limit expires, then rotates priority.
- Sits beside the child instances inside the root module and owns their access sequencing.

Parameters:
- NUM_REQ, 5, number of child requesters.
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held before forced revocation; legal range 1..255.
- HOLD_W, 8, width of the hold counter; must hold MAX_HOLD.
- ID_W, 3, width of requester index outputs; must be at least clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  NUM_REQ  per-child request level.
- done  input  NUM_REQ  per-child single-cycle release pulse.
- grant  output  NUM_REQ  one-hot grant; all zero when nothing is granted.
- grant_valid  output  1  OR of grant.
- grant_id  output  ID_W  index of the granted child; 0 when grant_valid=0.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.
- timeout_id  output  ID_W  index of the revoked child; valid with timeout, otherwise 0.
- busy  output  1  high in GRANT and GAP states.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - grant=0, grant_valid=0, grant_id=0, timeout=0, timeout_id=0, busy=0.
  - State=IDLE, priority pointer=0, hold counter=0.
- States:
  - IDLE: no grant.
  - GRANT: exactly one grant bit high.
  - GAP: one-cycle turnaround with no grant.
- IDLE:
  - If req is nonzero at edge t, select the first asserted bit searching from pointer upward, wrapping modulo NUM_REQ.
  - grant, grant_valid and grant_id become valid at edge t (registered); latency is one cycle from request to grant.
  - State goes to GRANT and the hold counter loads 1.
- GRANT, evaluated each edge for granted index g:
  - If done[g]=1 or req[g]=0: release, go to GAP, clear grant, no timeout.
  - Else if hold counter = MAX_HOLD: forced revocation, go to GAP, clear grant, timeout=1 and timeout_id=g for that one cycle.
  - Else: hold counter increments and the grant is held.
- Pointer update: on any exit from GRANT, pointer = (g+1) mod NUM_REQ. It wraps from NUM_REQ-1 to 0.
- GAP:
  - Lasts exactly one cycle with grant all zero.
  - Then arbitrates exactly as IDLE. The next grant appears at the end of the GAP cycle, or the state goes to IDLE if req=0.
  - A child is never granted in two back-to-back cycles across a release.
- done on a non-granted index is ignored. done in IDLE or GAP is ignored.
- Simultaneous done[g] and hold limit reached: the release wins and timeout stays 0.
- A timed-out child whose req is still high is eligible again after all other requesters have had their turn.
- req bits may change at any time. Only their value at the arbitration edge matters.
- A grant never changes one-hot position without passing through GAP.
- Reset asserted mid-grant: grant drops immediately (asynchronously). The pointer returns to 0 and any pending timeout pulse is suppressed.
- grant_valid and busy are registered with the same timing as grant, not combinational from req.

Test Plan:
- Single requester: after reset, req=5'b00100 held; done[2] pulsed on the 3rd granted cycle.
  - Required: grant=5'b00100 one cycle after req. Release at that edge, then one GAP cycle, then re-grant to 2 (only requester), pointer=3.
- All requesting: req=5'b11111, each child pulses done after 2 granted cycles.
  - Required: grant order 0,1,2,3,4,0, each grant separated by one all-zero GAP cycle.
- Wrap-around: pointer=4 (after granting 3), req=5'b01001.
  - Required: next grant is index 0, then index 3; index 4 is skipped.
- Timeout: MAX_HOLD=16, req[1] held with no done.
  - Required: grant[1] high for exactly 16 cycles, then timeout=1 with timeout_id=1 for one cycle, GAP, then re-grant to 1 if no other requester.
- Collision: done[1] pulsed on the same edge the hold counter reaches 16.
  - Required: timeout stays 0 and the pointer still advances to 2.
- Reset mid-grant: rst_n driven low while grant=5'b01000.
  - Required: grant=0 without waiting for a clock edge. After rst_n is released with req=5'b01010, the first grant goes to index 1.

Source files
------------

// File: rtl/child_rr_scheduler.sv
// Round-robin scheduler sharing one resource slot among the root module's child instances.
// One grant at a time, held until done/req drop or the hold limit, then a one-cycle gap.
module child_rr_scheduler #(
   parameter int NUM_REQ  = 5,
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8,
   parameter int ID_W     = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [ID_W-1:0]    grant_id,
   output logic               timeout,
   output logic [ID_W-1:0]    timeout_id,
   output logic               busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam logic [ID_W:0]     NUM_REQ_W = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [1:0]         state;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    gid;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [NUM_REQ-1:0] grant_r;
   logic               grant_valid_r;
   logic               busy_r;
   logic               timeout_r;
   logic [ID_W-1:0]    timeout_id_r;

   logic [ID_W:0]      pick;
   logic               pick_found;
   logic [ID_W-1:0]    pick_id;
   logic               release_now;
   logic               hold_full;

   // First asserted request at or above the pointer, wrapping modulo NUM_REQ.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [ID_W-1:0]    p);
      logic          found;
      logic [ID_W-1:0] sel;
      logic [ID_W:0] sum;
      logic [ID_W-1:0] cand;
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, p} + (ID_W+1)'(i);
         if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
         cand = sum[ID_W-1:0];
         if (!found && r[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      return {found, sel};
   endfunction

   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
      return (g == LAST_ID) ? '0 : g + 1'b1;
   endfunction

   always_comb begin
      pick        = rr_pick(req, ptr);
      pick_found  = pick[ID_W];
      pick_id     = pick[ID_W-1:0];
      // done on a non-granted child is masked out by the grant vector
      release_now = (|(grant_r & done)) || !(|(grant_r & req));
      hold_full   = (hold_cnt == HOLD_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         gid           <= '0;
         hold_cnt      <= '0;
         grant_r       <= '0;
         grant_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         timeout_r     <= 1'b0;
         timeout_id_r  <= '0;
      end else begin
         timeout_r    <= 1'b0;
         timeout_id_r <= '0;
         case (state)
            ST_IDLE, ST_GAP: begin
               if (pick_found) begin
                  state         <= ST_GRANT;
                  gid           <= pick_id;
                  grant_r       <= ONE_HOT0 << pick_id;
                  grant_valid_r <= 1'b1;
                  busy_r        <= 1'b1;
                  hold_cnt      <= HOLD_W'(1);
               end else begin
                  state         <= ST_IDLE;
                  gid           <= '0;
                  grant_r       <= '0;
                  grant_valid_r <= 1'b0;
                  busy_r        <= 1'b0;
                  hold_cnt      <= '0;
               end
            end
            ST_GRANT: begin
               if (release_now || hold_full) begin
                  // release has priority over the hold limit on the same edge
                  state         <= ST_GAP;
                  ptr           <= next_ptr(gid);
                  gid           <= '0;
                  grant_r       <= '0;
                  grant_valid_r <= 1'b0;
                  busy_r        <= 1'b1;
                  hold_cnt      <= '0;
                  if (!release_now) begin
                     timeout_r    <= 1'b1;
                     timeout_id_r <= gid;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state         <= ST_IDLE;
               gid           <= '0;
               grant_r       <= '0;
               grant_valid_r <= 1'b0;
               busy_r        <= 1'b0;
               hold_cnt      <= '0;
            end
         endcase
      end
   end

   assign grant       = grant_r;
   assign grant_valid = grant_valid_r;
   assign grant_id    = gid;
   assign busy        = busy_r;
   assign timeout     = timeout_r;
   assign timeout_id  = timeout_id_r;

endmodule

// File: tb/tb_child_rr_scheduler.sv
// Directed bench for child_rr_scheduler: reset, rotation, wrap, hold-limit timeout, collision, async reset.
module tb_child_rr_scheduler;

   logic       clk;
   logic       rst_n;
   logic [4:0] req;
   logic [4:0] done;
   logic [4:0] grant;
   logic       grant_valid;
   logic [2:0] grant_id;
   logic       timeout;
   logic [2:0] timeout_id;
   logic       busy;

   int tests;
   int fails;

   child_rr_scheduler #(.NUM_REQ(5), .MAX_HOLD(16), .HOLD_W(8), .ID_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done), .grant(grant),
      .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout),
      .timeout_id(timeout_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      tick();
      tests++; if (grant !== 5'b0) begin fails++; $display("FAIL reset_grant: got %b want %b", grant, 5'b0); end
      tests++; if ({grant_valid, busy, timeout} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {grant_valid, busy, timeout}); end
      tests++; if ({grant_id, timeout_id} !== 6'd0) begin fails++; $display("FAIL reset_ids: got %0d/%0d want 0/0", grant_id, timeout_id); end
      rst_n = 1'b1;
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      req = 5'b00100;
      tick();
      tests++; if (grant !== 5'b00100) begin fails++; $display("FAIL single_grant: got %b want 00100", grant); end
      tests++; if ({grant_valid, busy, grant_id} !== {1'b1, 1'b1, 3'd2}) begin fails++; $display("FAIL single_id: valid=%b busy=%b id=%0d want 1 1 2", grant_valid, busy, grant_id); end
      tick();
      tick();
      done = 5'b00100;
      tests++; if (grant !== 5'b00100) begin fails++; $display("FAIL single_hold3: got %b want 00100", grant); end
      tick();
      done = '0;
      tests++; if ({grant, grant_valid, busy, timeout} !== {5'b0, 1'b0, 1'b1, 1'b0}) begin fails++; $display("FAIL single_gap: grant=%b valid=%b busy=%b to=%b want 00000 0 1 0", grant, grant_valid, busy, timeout); end
      tick();
      tests++; if ({grant, grant_id} !== {5'b00100, 3'd2}) begin fails++; $display("FAIL single_regrant: grant=%b id=%0d want 00100 2", grant, grant_id); end
      req = '0;
      tick();
      tests++; if ({grant, busy} !== {5'b0, 1'b1}) begin fails++; $display("FAIL single_reqdrop: grant=%b busy=%b want 00000 1", grant, busy); end
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_all_requesting();
      int order [6] = '{0, 1, 2, 3, 4, 0};
      logic [4:0] exp;
      do_reset();
      req = 5'b11111;
      for (int k = 0; k < 6; k++) begin
         exp = 5'b00001 << order[k];
         tick();
         tests++; if ({grant, grant_id} !== {exp, 3'(order[k])}) begin fails++; $display("FAIL all_order[%0d]: grant=%b id=%0d want %b %0d", k, grant, grant_id, exp, order[k]); end
         tick();
         done = exp;
         tick();
         done = '0;
         tests++; if ({grant, busy} !== {5'b0, 1'b1}) begin fails++; $display("FAIL all_gap[%0d]: grant=%b busy=%b want 00000 1", k, grant, busy); end
      end
      req = '0;
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL all_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_wrap();
      req = 5'b01000;
      tick();
      tests++; if (grant !== 5'b01000) begin fails++; $display("FAIL wrap_setup: got %b want 01000", grant); end
      req = '0;
      tick();
      req = 5'b01001;
      tick();
      tests++; if ({grant, grant_id} !== {5'b00001, 3'd0}) begin fails++; $display("FAIL wrap_first: grant=%b id=%0d want 00001 0", grant, grant_id); end
      done = 5'b00001;
      tick();
      done = '0;
      tick();
      tests++; if ({grant, grant_id} !== {5'b01000, 3'd3}) begin fails++; $display("FAIL wrap_second: grant=%b id=%0d want 01000 3", grant, grant_id); end
      done = 5'b01000;
      req  = '0;
      tick();
      done = '0;
      tick();
   endtask

   task automatic test_timeout_and_collision();
      int held;
      req  = 5'b00010;
      held = 0;
      tick();
      for (int i = 0; i < 16; i++) begin
         if (grant === 5'b00010 && timeout === 1'b0) held++;
         if (i < 15) tick();
      end
      tests++; if (held !== 16) begin fails++; $display("FAIL timeout_held: cycles=%0d want 16", held); end
      tick();
      tests++; if ({timeout, timeout_id, grant} !== {1'b1, 3'd1, 5'b0}) begin fails++; $display("FAIL timeout_pulse: to=%b id=%0d grant=%b want 1 1 00000", timeout, timeout_id, grant); end
      tick();
      tests++; if ({grant, timeout, timeout_id} !== {5'b00010, 1'b0, 3'd0}) begin fails++; $display("FAIL timeout_regrant: grant=%b to=%b id=%0d want 00010 0 0", grant, timeout, timeout_id); end
      for (int i = 0; i < 15; i++) tick();
      done = 5'b00010;
      tests++; if (grant !== 5'b00010) begin fails++; $display("FAIL collide_hold16: got %b want 00010", grant); end
      tick();
      done = '0;
      tests++; if ({timeout, grant} !== {1'b0, 5'b0}) begin fails++; $display("FAIL collide_timeout: to=%b grant=%b want 0 00000", timeout, grant); end
      req = 5'b00011;
      tick();
      tests++; if (grant !== 5'b00001) begin fails++; $display("FAIL collide_ptr: grant=%b want 00001", grant); end
      done = 5'b00001;
      req  = '0;
      tick();
      done = '0;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      req = 5'b00010;
      tick();
      req = '0;
      tick();
      req = 5'b01000;
      tick();
      tests++; if (grant !== 5'b01000) begin fails++; $display("FAIL rstmid_setup: got %b want 01000", grant); end
      #1 rst_n = 1'b0;
      #1;
      tests++; if ({grant, grant_valid, busy} !== {5'b0, 1'b0, 1'b0}) begin fails++; $display("FAIL rstmid_async: grant=%b valid=%b busy=%b want 00000 0 0", grant, grant_valid, busy); end
      req = 5'b01010;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tests++; if ({grant, grant_id} !== {5'b00010, 3'd1}) begin fails++; $display("FAIL rstmid_first: grant=%b id=%0d want 00010 1", grant, grant_id); end
      req = '0;
      tick();
      tick();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      test_reset();
      test_single();
      test_all_requesting();
      test_wrap();
      test_timeout_and_collision();
      test_reset_mid_grant();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
